// File: rtl/cordic_op_sequencer.sv
// ---------------------------------------------------------------------------
// cordic_op_sequencer
//
// Purpose: accepts one CORDIC-family request at a time, maps its function
// code to one of six function units (U0..U5), pulses that unit's start bit,
// waits for that unit's done pulse (or a timeout), and returns the result
// through a valid/ready response port.
//
// Optional feature macro: CORDIC_SEQ_STATS_EN
//   When defined, adds the saturating stat_ops / stat_errs counters.
//
// Ports:
//   clk, rst            single clock, synchronous active-high reset
//   req_valid/req_ready request handshake (ready only in IDLE)
//   req_func            4-bit function code
//   req_op1/req_op2     signed operands (OPW bits)
//   unit_start[5:0]     one-hot single-cycle start pulse to U0..U5
//   unit_func/op1/op2   latched request fields, stable ISSUE..WAIT
//   unit_done[5:0]      per-unit completion pulses
//   unit_result         flat 6*RESW bus, unit i at [i*RESW +: RESW]
//   rsp_valid/rsp_ready response handshake
//   rsp_result/rsp_err  response payload
//   busy                high whenever not IDLE
//   stat_ops/stat_errs  (CORDIC_SEQ_STATS_EN only) handshake counters
// ---------------------------------------------------------------------------
module cordic_op_sequencer #(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int OPW            = 16,
  parameter int RESW           = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [3:0]          req_func,
  input  logic [OPW-1:0]      req_op1,
  input  logic [OPW-1:0]      req_op2,
  output logic [5:0]          unit_start,
  output logic [3:0]          unit_func,
  output logic [OPW-1:0]      unit_op1,
  output logic [OPW-1:0]      unit_op2,
  input  logic [5:0]          unit_done,
  input  logic [6*RESW-1:0]   unit_result,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [RESW-1:0]     rsp_result,
  output logic                rsp_err,
  output logic                busy
`ifdef CORDIC_SEQ_STATS_EN
  ,
  output logic [15:0]         stat_ops,
  output logic [15:0]         stat_errs
`endif
);

  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t          r_state, w_state_next;
  logic [3:0]      r_func, w_func_next;
  logic [OPW-1:0]  r_op1, w_op1_next;
  logic [OPW-1:0]  r_op2, w_op2_next;
  logic [2:0]      r_sel, w_sel_next;
  logic [CW-1:0]   r_cnt, w_cnt_next;
  logic [RESW-1:0] r_result, w_result_next;
  logic            r_err, w_err_next;

  // Function-code decode
  logic            w_dec_legal;
  logic [2:0]      w_dec_sel;

  always_comb begin
    w_dec_legal = 1'b1;
    w_dec_sel   = 3'd0;
    case (req_func)
      4'd0, 4'd1: w_dec_sel = 3'd0;
      4'd2, 4'd3: w_dec_sel = 3'd1;
      4'd4, 4'd5: w_dec_sel = 3'd2;
      4'd7:       w_dec_sel = 3'd3;
      4'd8:       w_dec_sel = 3'd4;
      4'd9:       w_dec_sel = 3'd5;
      default:    w_dec_legal = 1'b0;
    endcase
  end

  // Per-unit selection: only the latched unit's done/result are visible,
  // everything else is masked to zero before the OR-reduction.
  logic [5:0]      w_sel_oh;
  logic [RESW-1:0] w_masked [6];
  logic            w_sel_done;
  logic [RESW-1:0] w_sel_result;

  for (genvar gi = 0; gi < 6; gi++) begin : g_unit
    assign w_sel_oh[gi]   = (r_sel == 3'(gi));
    assign w_masked[gi]   = w_sel_oh[gi] ? unit_result[gi*RESW +: RESW] : '0;
    assign unit_start[gi] = (r_state == S_ISSUE) && w_sel_oh[gi];
  end

  assign w_sel_done = |(unit_done & w_sel_oh);

  always_comb begin
    w_sel_result = '0;
    for (int i = 0; i < 6; i++) begin
      w_sel_result = w_sel_result | w_masked[i];
    end
  end

  // State register and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_func   <= '0;
      r_op1    <= '0;
      r_op2    <= '0;
      r_sel    <= '0;
      r_cnt    <= '0;
      r_result <= '0;
      r_err    <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_func   <= w_func_next;
      r_op1    <= w_op1_next;
      r_op2    <= w_op2_next;
      r_sel    <= w_sel_next;
      r_cnt    <= w_cnt_next;
      r_result <= w_result_next;
      r_err    <= w_err_next;
    end
  end

  // Next-state and datapath next values
  always_comb begin
    w_state_next  = r_state;
    w_func_next   = r_func;
    w_op1_next    = r_op1;
    w_op2_next    = r_op2;
    w_sel_next    = r_sel;
    w_cnt_next    = r_cnt;
    w_result_next = r_result;
    w_err_next    = r_err;
    case (r_state)
      S_IDLE: begin
        if (req_valid && req_ready) begin
          w_func_next = req_func;
          w_op1_next  = req_op1;
          w_op2_next  = req_op2;
          if (w_dec_legal) begin
            w_sel_next   = w_dec_sel;
            w_state_next = S_ISSUE;
          end else begin
            // Illegal codes skip the units and answer with an error at once
            w_err_next    = 1'b1;
            w_result_next = '0;
            w_state_next  = S_RESP;
          end
        end
      end
      S_ISSUE: begin
        w_cnt_next   = '0;
        w_state_next = S_WAIT;
      end
      S_WAIT: begin
        // Done is tested first so it wins over a coincident timeout
        if (w_sel_done) begin
          w_result_next = w_sel_result;
          w_err_next    = 1'b0;
          w_state_next  = S_RESP;
        end else if (r_cnt == CNT_LAST) begin
          w_result_next = '0;
          w_err_next    = 1'b1;
          w_state_next  = S_RESP;
        end else begin
          w_cnt_next = r_cnt + CW'(1);
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  assign req_ready  = (r_state == S_IDLE);
  assign busy       = (r_state != S_IDLE);
  assign rsp_valid  = (r_state == S_RESP);
  assign rsp_result = r_result;
  assign rsp_err    = r_err;
  assign unit_func  = r_func;
  assign unit_op1   = r_op1;
  assign unit_op2   = r_op2;

`ifdef CORDIC_SEQ_STATS_EN
  logic [15:0] r_stat_ops;
  logic [15:0] r_stat_errs;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stat_ops  <= '0;
      r_stat_errs <= '0;
    end else if (rsp_valid && rsp_ready) begin
      if (r_stat_ops != 16'hFFFF) begin
        r_stat_ops <= r_stat_ops + 16'd1;
      end
      if (r_err && (r_stat_errs != 16'hFFFF)) begin
        r_stat_errs <= r_stat_errs + 16'd1;
      end
    end
  end

  assign stat_ops  = r_stat_ops;
  assign stat_errs = r_stat_errs;
`endif

endmodule
